// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StSend,
    StRelease
  } arb_state_e;

  localparam int unsigned UART_FRAME_BITS      = 10;
  localparam int unsigned UART_TIMEOUT_DEFAULT = 15000;
  localparam int unsigned LOCK_BURST_MAX       = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: search starts one past the last granted requester.
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic               valid_o,
  output logic [IdxW-1:0]    winner_o,
  output logic [NUM_REQ-1:0] onehot_o
);

  int unsigned      pos;
  logic [IdxW-1:0]  idx;

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    onehot_o = '0;
    pos      = 0;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      // last_i < NUM_REQ and k <= NUM_REQ, so one subtraction is enough for the modulo
      pos = 32'(last_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = IdxW'(pos);
      if (!valid_o && req_i[idx]) begin
        valid_o       = 1'b1;
        winner_o      = idx;
        onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one Uart8 transmitter between NUM_REQ byte sources.
// Define UART_TX_ARB_LOCK_EN to let the owner hold the transmitter for bursts of up to 16 bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = UART_TIMEOUT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_byte_i,
  input  logic [NUM_REQ-1:0]   req_lock_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 sent_done_o,
  output logic                 timeout_err_o,
  output logic                 busy_o,
  output logic                 tx_en_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_byte_o,
  input  logic                 tx_busy_i,
  input  logic                 tx_done_i
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned CntW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BurstW = $clog2(LOCK_BURST_MAX);
  localparam logic [CntW-1:0]   CntLast   = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(LOCK_BURST_MAX - 1);

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d, owner_q, owner_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [7:0]          byte_q, byte_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, ready_q, ready_d;
  logic                sent_q, sent_d, tmo_q, tmo_d;
  logic                done_q, en_q;

  logic [7:0]          req_bytes [NUM_REQ];
  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  logic                done_rise, cnt_last, lock_req, lock_go;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_byte_i[8*g +: 8];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_pick (
    .req_i    (req_valid_i),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .winner_o (pick_idx),
    .onehot_o (pick_oh)
  );

`ifdef UART_TX_ARB_LOCK_EN
  assign lock_req = req_lock_i[owner_q];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock_i;
  assign lock_req    = 1'b0;
`endif

  assign done_rise = tx_done_i & ~done_q;
  assign cnt_last  = (cnt_q == CntLast);
  assign lock_go   = lock_req & req_valid_i[owner_q] & (burst_q != BurstLast);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    byte_d  = byte_q;
    grant_d = grant_q;
    ready_d = '0;
    sent_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          byte_d  = req_bytes[pick_idx];
          ready_d = pick_oh;
          grant_d = pick_oh;
          cnt_d   = '0;
          burst_d = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_last) begin
          tmo_d   = 1'b1;
          last_d  = owner_q;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (tx_busy_i) state_d = StSend;
        end
      end
      StSend: begin
        // A completed frame wins over the terminal count
        if (done_rise) begin
          sent_d  = 1'b1;
          last_d  = owner_q;
          state_d = StRelease;
        end else if (cnt_last) begin
          tmo_d   = 1'b1;
          last_d  = owner_q;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (lock_go) begin
          byte_d           = req_bytes[owner_q];
          ready_d[owner_q] = 1'b1;
          cnt_d            = '0;
          burst_d          = burst_q + 1'b1;
          state_d          = StStart;
        end else begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= IdxW'(NUM_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      byte_q  <= '0;
      grant_q <= '0;
      ready_q <= '0;
      sent_q  <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      byte_q  <= byte_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      sent_q  <= sent_d;
      tmo_q   <= tmo_d;
      done_q  <= tx_done_i;
      en_q    <= 1'b1;
    end
  end

  assign req_ready_o   = ready_q;
  assign grant_o       = grant_q;
  assign sent_done_o   = sent_q;
  assign timeout_err_o = tmo_q;
  assign busy_o        = (state_q != StIdle);
  assign tx_en_o       = en_q;
  assign tx_start_o    = (state_q == StStart);
  assign tx_byte_o     = byte_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Param NUM_REQ, default 4, number of requesters sharing one Uart8 transmitter (2..8).
REQ-002 Param TIMEOUT_CYCLES, default 15000, clk cycles from txStart assertion to txDone rise before abort (12 MHz, 9600 baud, 10-bit frame plus margin).
REQ-003 clk  in  1  system clock, same clock as Uart8 clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 reqValid  in  NUM_REQ  per-requester byte-available flag.
REQ-006 reqByte  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 reqLock  in  NUM_REQ  per-requester burst-hold request; used only when the configuration macro is defined.
REQ-008 reqReady  out  NUM_REQ  one-cycle accept pulse to the winning requester.
REQ-009 grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
REQ-010 sentDone  out  1  one-cycle pulse when the granted byte has been fully sent.
REQ-011 timeoutErr  out  1  one-cycle pulse when a transfer is aborted on timeout.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 txEn, txStart, txByte[7:0]  out  to Uart8 txEn, txStart and in.
REQ-014 txBusy, txDone  in  1 each  from Uart8.

Function
REQ-015 The FSM SHALL have states IDLE, START, SEND and RELEASE, encoded as an enum.
REQ-016 txEn SHALL be 1 in every state after reset is released.
REQ-017 IDLE: with any reqValid high, pick the winner round-robin, searching from lastGrant+1 modulo NUM_REQ.
REQ-018 On winning: latch reqByte of the winner into txByte, pulse reqReady[winner] for one cycle, set grant, go to START on the same edge.
REQ-019 START: hold txStart=1 until txBusy is sampled high (Uart8 tx runs on the baud clock), then go to SEND with txStart=0.
REQ-020 SEND: on a rising edge of txDone (registered edge detect), pulse sentDone, set lastGrant=winner, go to RELEASE.
REQ-021 RELEASE: go to IDLE after one cycle with grant cleared, giving a minimum one-cycle gap between frames.
REQ-022 Timeout counter: cleared on entry to START, counts in START and SEND; reaching TIMEOUT_CYCLES-1 pulses timeoutErr, drops txStart, updates lastGrant and goes to RELEASE.
REQ-023 txByte SHALL stay stable from acceptance until RELEASE.
REQ-024 reqValid or reqByte changes after acceptance SHALL have no effect on the transfer in flight.
REQ-025 reqValid of a non-granted requester SHALL be ignored until IDLE.
REQ-026 sentDone and timeoutErr SHALL never assert in the same cycle; txDone takes precedence on the terminal-count cycle.
REQ-027 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); no wrap-around.
REQ-028 A txDone rise seen in IDLE or START SHALL be ignored.

Reset
REQ-029 Asserting reset (asynchronously, including mid-frame) SHALL force IDLE, lastGrant=NUM_REQ-1 (requester 0 wins first), counter=0, edge register=0, txByte=0.
REQ-030 During reset, all outputs SHALL be 0: reqReady, grant, sentDone, timeoutErr, busy, txEn, txStart.

Configuration
REQ-031 Macro UART_TX_ARB_LOCK_EN defined: in RELEASE, if reqLock and reqValid of the owner are both high, accept its next byte directly (reqReady pulse, go to START) and keep grant without round-robin.
REQ-032 Locked bursts SHALL be capped at 16 consecutive bytes, after which the FSM goes to IDLE for arbitration.
REQ-033 Macro undefined: reqLock SHALL be ignored and every frame re-arbitrates.

Structure
REQ-034 Shared package uart_pkg SHALL hold the FSM state enum, the UART_FRAME_BITS=10 constant and a default TIMEOUT constant.
REQ-035 Sub-module uart_rr_pick SHALL hold the combinational round-robin one-hot selector (NUM_REQ, lastGrant -> winner); the FSM stays in the top level.

Verification
REQ-036 Reset, then reqValid=0001 with byte 8'hD5 -> reqReady[0] pulses, txByte=8'hD5, line frame 0,10101011,1, one sentDone pulse.
REQ-037 reqValid=1111 held continuously -> grant order 0,1,2,3,0, one sentDone per frame, no back-to-back grant to the same requester.
REQ-038 Stubbed txDone never rises -> timeoutErr pulses exactly 15000 cycles after txStart rises, grant passes to the next requester.
REQ-039 Reset asserted mid-SEND -> all outputs 0 within the same timestep; after release requester 0 wins first.
REQ-040 With UART_TX_ARB_LOCK_EN, reqLock[2]=1 and reqValid=0110 -> requester 2 sends up to 16 consecutive bytes, then requester 1 is granted; without the macro, grants alternate 1,2,1,2.
